// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Brief    : Valid/ready beat bus between MIPS pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int WORD_W     = 32,
    parameter int REG_W      = 5,
    parameter int DATA_LANES = 2
);
    logic                         valid;
    logic                         ready;
    logic [WORD_W-1:0]            pc;
    logic [WORD_W-1:0]            instr;
    logic [DATA_LANES*WORD_W-1:0] data;
    logic [REG_W-1:0]             write_reg;

    modport master (output valid, pc, instr, data, write_reg, input  ready);
    modport slave  (input  valid, pc, instr, data, write_reg, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Pipeline stage register with valid/ready, stall hold and flush.
//            Define STAGE_REG_SKID_EN for the 2-entry skid (registered in_ready).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WORD_W     = 32,
    parameter int REG_W      = 5,
    parameter int DATA_LANES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  in_bus,
    pipe_stage_reg_if.master out_bus,
    output logic [1:0]       count
);
    localparam int c_DATA_W    = DATA_LANES * WORD_W;
    localparam int c_PAYLOAD_W = 2 * WORD_W + c_DATA_W + REG_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_valid;
    logic [1:0]               r_count;
    logic [c_PAYLOAD_W-1:0]   r_main;
`ifdef STAGE_REG_SKID_EN
    logic [c_PAYLOAD_W-1:0]   r_skid;
    logic                     r_in_ready;
`endif

    logic [c_PAYLOAD_W-1:0]   w_in_payload;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_pop;

    assign w_in_payload = {in_bus.pc, in_bus.instr, in_bus.data, in_bus.write_reg};

`ifdef STAGE_REG_SKID_EN
    // Registered ready breaks the combinational stall chain across stages.
    assign w_in_ready = r_in_ready;
`else
    assign w_in_ready = !r_valid | out_bus.ready;
`endif

    assign w_accept     = in_bus.valid & w_in_ready;
    assign w_pop        = r_valid & out_bus.ready;
    assign in_bus.ready = w_in_ready;

    assign out_bus.valid = r_valid;
    assign {out_bus.pc, out_bus.instr, out_bus.data, out_bus.write_reg} = r_main;
    assign count = r_count;

    // Empty slots are held at zero so an idle stage presents a nop to $zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_count    <= 2'd0;
            r_main     <= '0;
`ifdef STAGE_REG_SKID_EN
            r_skid     <= '0;
            r_in_ready <= 1'b1;
`endif
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_count    <= 2'd0;
            r_main     <= '0;
`ifdef STAGE_REG_SKID_EN
            r_skid     <= '0;
            r_in_ready <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_ONE;
                        r_valid <= 1'b1;
                        r_count <= 2'd1;
                        r_main  <= w_in_payload;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= w_in_payload;
`ifdef STAGE_REG_SKID_EN
                    end else if (w_accept) begin
                        r_state    <= ST_FULL;
                        r_count    <= 2'd2;
                        r_skid     <= w_in_payload;
                        r_in_ready <= 1'b0;
`endif
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                        r_count <= 2'd0;
                        r_main  <= '0;
                    end
                end
`ifdef STAGE_REG_SKID_EN
                ST_FULL: begin
                    if (w_pop) begin
                        r_state    <= ST_ONE;
                        r_count    <= 2'd1;
                        r_main     <= r_skid;
                        r_skid     <= '0;
                        r_in_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                    r_count <= 2'd0;
                    r_main  <= '0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed, table-driven bench for pipe_stage_reg (both skid builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    localparam int c_WORD_W     = 32;
    localparam int c_REG_W      = 5;
    localparam int c_DATA_LANES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_reg_if #(.WORD_W(c_WORD_W), .REG_W(c_REG_W), .DATA_LANES(c_DATA_LANES)) up_if ();
    pipe_stage_reg_if #(.WORD_W(c_WORD_W), .REG_W(c_REG_W), .DATA_LANES(c_DATA_LANES)) dn_if ();

    pipe_stage_reg #(
        .WORD_W     (c_WORD_W),
        .REG_W      (c_REG_W),
        .DATA_LANES (c_DATA_LANES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_bus  (up_if),
        .out_bus (dn_if),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Payload fields are derived from the pc so one number describes a beat.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc + 32'h1000_0000;
    endfunction
    function automatic logic [63:0] data_of(input logic [31:0] pc);
        return {pc + 32'd2, pc + 32'd1};
    endfunction
    function automatic logic [4:0] wr_of(input logic [31:0] pc);
        return pc[6:2];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
        flush           = fl;
        up_if.valid     = iv;
        up_if.pc        = pc;
        up_if.instr     = instr_of(pc);
        up_if.data      = data_of(pc);
        up_if.write_reg = wr_of(pc);
        dn_if.ready     = ordy;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [1:0] ecnt, input logic erdy);
        chk({tag, "_valid"}, 64'(dn_if.valid), 64'(ev));
        chk({tag, "_count"}, 64'(count), 64'(ecnt));
        chk({tag, "_in_ready"}, 64'(up_if.ready), 64'(erdy));
        chk({tag, "_pc"}, 64'(dn_if.pc), ev ? 64'(epc) : 64'd0);
        chk({tag, "_instr"}, 64'(dn_if.instr), ev ? 64'(instr_of(epc)) : 64'd0);
        chk({tag, "_data"}, dn_if.data, ev ? data_of(epc) : 64'd0);
        chk({tag, "_wreg"}, 64'(dn_if.write_reg), ev ? 64'(wr_of(epc)) : 64'd0);
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        ev;
        logic [31:0] epc;
        logic [1:0]  ecnt;
        logic        erdy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Each row: inputs applied at the negedge, expected outputs observed
        // 1 ns later (state from earlier edges, ready from current inputs).
        vecs[0]  = '{1'b0, 1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 32'h0040_0004, 1'b1, 1'b1, 32'h0040_0000, 2'd1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 32'h0040_0008, 1'b1, 1'b1, 32'h0040_0004, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h0040_000C, 1'b1, 1'b1, 32'h0040_0008, 2'd1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_000C, 2'd1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_0010, 2'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0,          2'd0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0304, 1'b1, 1'b1, 32'h0000_0300, 2'd1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0304, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'h0000_0404, 1'b1, 1'b1, 32'h0000_0400, 2'd1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          2'd0, 1'b1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); #1;
        check_state("reset", 1'b0, 32'h0, 2'd0, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ecnt, vecs[i].erdy);
        end

        // Asynchronous reset while holding a load word, between clock edges.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0000_0600, 1'b0);
        up_if.instr = 32'h8C82_0004;
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("rst_mid_pre_valid", 64'(dn_if.valid), 64'd1);
        chk("rst_mid_pre_instr", 64'(dn_if.instr), 64'h8C82_0004);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(dn_if.valid), 64'd0);
        chk("rst_mid_instr", 64'(dn_if.instr), 64'd0);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_in_ready", 64'(up_if.ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

`ifdef STAGE_REG_SKID_EN
        // Skid fill and drain.
        @(negedge clk); drive(1'b0, 1'b1, 32'h100, 1'b0); #1; check_state("skid0", 1'b0, 32'h0,   2'd0, 1'b1);
        @(negedge clk); drive(1'b0, 1'b1, 32'h104, 1'b0); #1; check_state("skid1", 1'b1, 32'h100, 2'd1, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b0); #1; check_state("skid2", 1'b1, 32'h100, 2'd2, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b1); #1; check_state("skid3", 1'b1, 32'h100, 2'd2, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b1); #1; check_state("skid4", 1'b1, 32'h104, 2'd1, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b1); #1; check_state("skid5", 1'b0, 32'h0,   2'd0, 1'b1);
        // Flush from FULL with a beat offered; nothing may emerge afterwards.
        @(negedge clk); drive(1'b0, 1'b1, 32'h110, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 32'h114, 1'b0);
        @(negedge clk); drive(1'b1, 1'b1, 32'h200, 1'b0); #1; check_state("flush0", 1'b1, 32'h110, 2'd2, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b1); #1; check_state("flush1", 1'b0, 32'h0,   2'd0, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b1); #1; check_state("flush2", 1'b0, 32'h0,   2'd0, 1'b1);
`else
        // Single-entry: ready follows out_ready combinationally, then replaces.
        @(negedge clk); drive(1'b0, 1'b1, 32'h500, 1'b0); #1; check_state("ne0", 1'b0, 32'h0,   2'd0, 1'b1);
        @(negedge clk); drive(1'b0, 1'b1, 32'h504, 1'b0); #1; check_state("ne1", 1'b1, 32'h500, 2'd1, 1'b0);
        dn_if.ready = 1'b1;
        #1;
        chk("ne1_in_ready_comb", 64'(up_if.ready), 64'd1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b1); #1; check_state("ne2", 1'b1, 32'h504, 2'd1, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0,   1'b1); #1; check_state("ne3", 1'b0, 32'h0,   2'd0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
